// File: rtl/module_trap_unit.sv
// rtl/module_trap_unit.sv - trap/interrupt/MRET sequencer feeding module_csr
module module_trap_unit #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_next,
  input  logic            exc_ebreak,
  input  logic            exc_illegal,
  input  logic            exc_ecall,
  input  logic            exc_fetch_mis,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            mstatus_we,
  input  logic [XLEN-1:0] mstatus_din,
  input  logic [XLEN-1:0] mtvec_dout,
  input  logic [XLEN-1:0] mepc_dout,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_din,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_din,
  output logic [XLEN-1:0] mstatus_dout,
  output logic            stall,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_target,
  input  logic            redir_ready
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic                   mie;
  logic                   mpie;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   ext_s;
  logic                   exc_any;
  logic                   int_any;
  logic                   take_trap;
  logic                   take_mret;
  logic                   accept;
  logic [4:0]             code;
  logic [XLEN-1:0]        cause_q;
  logic [XLEN-1:0]        epc_q;
  logic [XLEN-1:0]        target_q;
  logic [XLEN-1:0]        tvec_base;
  logic                   tvec_vectored;
  logic                   unused_mstatus_bits;

  // Only MIE and MPIE are implemented in mstatus; the other write bits are dropped.
  assign unused_mstatus_bits = ^{mstatus_din[XLEN-1:8], mstatus_din[6:4], mstatus_din[2:0]};

  // Multi-flop synchroniser for the asynchronous external interrupt line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_sync <= '0;
    else        irq_sync <= {irq_sync[SYNC_STAGES-2:0], ext_irq};
  end

  assign ext_s = irq_sync[SYNC_STAGES-1];

  // Event decode and fixed priority: exceptions, then ext irq, then timer, then MRET
  always_comb begin
    exc_any   = exc_ebreak | exc_illegal | exc_ecall | exc_fetch_mis;
    int_any   = mie & (ext_s | timer_irq);
    take_trap = instr_valid & (exc_any | int_any);
    take_mret = instr_valid & mret & ~(exc_any | int_any);
    accept    = (state == IDLE) & (take_trap | take_mret);
    code      = 5'd0;
    if (exc_ebreak)         code = 5'd3;
    else if (exc_illegal)   code = 5'd2;
    else if (exc_ecall)     code = 5'd11;
    else if (exc_fetch_mis) code = 5'd0;
    else if (ext_s)         code = 5'd11;
    else                    code = 5'd7;
  end

  // Trap vector: vectored mode only applies to interrupts
  always_comb begin
    tvec_base     = mtvec_dout & ALIGN_MASK;
    tvec_vectored = (VECTORED_EN != 0) && cause_q[XLEN-1] && (mtvec_dout[1:0] == 2'b01);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (take_trap)      state_nx = SAVE;
        else if (take_mret) state_nx = REDIR;
      end
      SAVE:    state_nx = REDIR;
      REDIR:   if (redir_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    mepc_we     = (state == SAVE);
    mcause_we   = (state == SAVE);
    redir_valid = (state == REDIR);
    stall       = (state != IDLE) | accept;
  end

  // Latch cause/epc on accept and the redirect address before REDIR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap) begin
            cause_q <= {~exc_any, {(XLEN-6){1'b0}}, code};
            epc_q   <= (exc_any ? pc : pc_next) & ALIGN_MASK;
          end else if (take_mret) begin
            target_q <= mepc_dout & ALIGN_MASK;
          end
        end
        SAVE: begin
          target_q <= tvec_vectored ? tvec_base + XLEN'({cause_q[4:0], 2'b00}) : tvec_base;
        end
        default: ;
      endcase
    end
  end

  // mstatus MIE/MPIE: trap entry stacks, MRET unstacks, CSR writes only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie  <= 1'b0;
      mpie <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_mret && !take_trap) begin
            mie  <= mpie;
            mpie <= 1'b1;
          end else if (!take_trap && mstatus_we) begin
            mie  <= mstatus_din[3];
            mpie <= mstatus_din[7];
          end
        end
        SAVE: begin
          mpie <= mie;
          mie  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mepc_din     = epc_q;
  assign mcause_din   = cause_q;
  assign redir_target = target_q;
  assign mstatus_dout = {{(XLEN-8){1'b0}}, mpie, 3'b000, mie, 3'b000};

endmodule
